// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   calc_nstg : number of pipeline stages for a WIDTH/CHUNK split.
//   split_ok  : true when WIDTH divides evenly into CHUNK-bit slices.
package pipe_adder_pkg;

    function automatic int calc_nstg(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit split_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// CHUNK-bit combinational adder slice with carry in and carry out.
// Ports:
//   a_i, b_i : CHUNK-bit operand slices
//   c_i      : carry into the slice
//   s_o      : CHUNK-bit sum slice
//   c_o      : carry out of the slice
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);

    // One extra bit on every term so the carry out falls into the MSB.
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit with a valid/ready handshake.
// The add is split into CHUNK-bit slices, one per stage, with the carry
// registered between stages. All stages advance together (global stall).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake
//   a, b, cin, sub      : operands; sub=1 computes a-b, ignoring cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, raw MSB carry out, two's-complement overflow
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = calc_nstg(WIDTH, CHUNK);
    localparam int MSB  = WIDTH - 1;

    if (!split_ok(WIDTH, CHUNK)) begin : g_bad_split
        $fatal(1, "pipe_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    // Inputs seen by each stage: port values for stage 0, the previous
    // stage's registers otherwise.
    logic             v_in [NSTG];
    logic [WIDTH-1:0] a_in [NSTG];
    logic [WIDTH-1:0] b_in [NSTG];
    logic [WIDTH-1:0] s_in [NSTG];
    logic             c_in [NSTG];

    logic adv;

    // Everything holds while a result waits for a consumer.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Bubbles enter with zero operands so idle outputs settle to 0
    // instead of echoing whatever sits on the operand bus.
    assign v_in[0] = in_valid;
    assign a_in[0] = in_valid ? a : '0;
    assign b_in[0] = in_valid ? (sub ? ~b : b) : '0;
    assign c_in[0] = in_valid && (sub || cin);
    assign s_in[0] = '0;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [CHUNK-1:0] s_slice;
        logic             c_slice;
        logic [WIDTH-1:0] s_d;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a_i (a_in[k][k*CHUNK +: CHUNK]),
            .b_i (b_in[k][k*CHUNK +: CHUNK]),
            .c_i (c_in[k]),
            .s_o (s_slice),
            .c_o (c_slice)
        );

        // Lower slices pass through; this stage fills in slice k.
        always_comb begin
            s_d                   = s_in[k];
            s_d[k*CHUNK +: CHUNK] = s_slice;
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples its predecessor's pre-edge value.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in[k];
                c_q <= c_slice;
                s_q <= s_d;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            // Operands still needed by later stages travel alongside.
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // NOTE: data registers are cleared on reset as well, not just
            // the valid bits, so the outputs are 0 after reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[k];
                    b_q <= b_in[k];
                end
            end

            assign v_in[k+1] = v_q;
            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
            assign s_in[k+1] = s_q;
            assign c_in[k+1] = c_q;
        end else begin : g_out
            logic ovf_d;
            logic ovf_q;

            // Overflow: operands agree in sign but the result does not.
            assign ovf_d = (a_in[k][MSB] == b_in[k][MSB]) && (s_d[MSB] != a_in[k][MSB]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign out_valid = v_q;
            assign sum       = s_q;
            assign cout      = c_q;
            assign ovf       = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a_drv;
    logic [63:0] b_drv;
    logic        cin_drv;
    logic        sub_drv;
    int          sel;

    int n_vec = 0;
    int n_err = 0;

    // Per-configuration DUT signals.
    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic        co0, co1, co2, co3;
    logic        of0, of1, of2, of3;
    logic [31:0] sum0, sum1;
    logic [15:0] sum2;
    logic [63:0] sum3;

    logic        cur_in_ready, cur_valid, cur_cout, cur_ovf;
    logic [63:0] cur_sum;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir0),
        .a(a_drv[31:0]), .b(b_drv[31:0]), .cin(cin_drv), .sub(sub_drv),
        .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .cout(co0), .ovf(of0));

    pipe_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir1),
        .a(a_drv[31:0]), .b(b_drv[31:0]), .cin(cin_drv), .sub(sub_drv),
        .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .cout(co1), .ovf(of1));

    pipe_adder #(.WIDTH(16), .CHUNK(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir2),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin_drv), .sub(sub_drv),
        .out_valid(ov2), .out_ready(out_ready), .sum(sum2), .cout(co2), .ovf(of2));

    pipe_adder #(.WIDTH(64), .CHUNK(16)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 3), .in_ready(ir3),
        .a(a_drv), .b(b_drv), .cin(cin_drv), .sub(sub_drv),
        .out_valid(ov3), .out_ready(out_ready), .sum(sum3), .cout(co3), .ovf(of3));

    always_comb begin
        cur_in_ready = ir0;
        cur_valid    = ov0;
        cur_sum      = {32'b0, sum0};
        cur_cout     = co0;
        cur_ovf      = of0;
        case (sel)
            1: begin cur_in_ready = ir1; cur_valid = ov1; cur_sum = {32'b0, sum1}; cur_cout = co1; cur_ovf = of1; end
            2: begin cur_in_ready = ir2; cur_valid = ov2; cur_sum = {48'b0, sum2}; cur_cout = co2; cur_ovf = of2; end
            3: begin cur_in_ready = ir3; cur_valid = ov3; cur_sum = sum3;          cur_cout = co3; cur_ovf = of3; end
            default: ;
        endcase
    end

    function automatic int width_of(input int s);
        case (s)
            1:       return 32;
            2:       return 16;
            3:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int nstg_of(input int s);
        return (s == 1) ? 1 : 4;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: a + beff + c0 at WIDTH+1 bits, overflow from operand/result signs.
    function automatic res_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic ci, input logic sb, input int w);
        res_t        r;
        logic [63:0] m;
        logic [63:0] am;
        logic [63:0] be;
        logic [64:0] total;
        m     = mask_of(w);
        am    = av & m;
        be    = sb ? (~bv & m) : (bv & m);
        total = {1'b0, am} + {1'b0, be} + {64'b0, (sb ? 1'b1 : ci)};
        r.sum  = total[63:0] & m;
        r.cout = total[w];
        r.ovf  = (am[w-1] == be[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated op with out_ready=1; checks latency and the result.
    task automatic run_one(input string name, input logic [63:0] av, input logic [63:0] bv,
                           input logic ci, input logic sb, input logic [63:0] es,
                           input logic ec, input logic eo);
        int lat;
        bit seen;
        a_drv = av; b_drv = bv; cin_drv = ci; sub_drv = sb;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_vec++;
        if (cur_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL [cfg%0d] %s in_ready: got %b expected 1", sel, name, cur_in_ready);
        end
        tick();
        in_valid = 1'b0; a_drv = '0; b_drv = '0; cin_drv = 1'b0; sub_drv = 1'b0;
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            if (cur_valid === 1'b1) seen = 1;
            else begin
                n_vec++;
                if (cur_in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL [cfg%0d] %s in_ready while empty: got %b expected 1", sel, name, cur_in_ready);
                end
                tick();
                lat++;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL [cfg%0d] %s timeout: out_valid never rose within 16 cycles", sel, name);
        end else begin
            if (lat != nstg_of(sel)) begin
                n_err++;
                $display("FAIL [cfg%0d] %s latency: got %0d expected %0d", sel, name, lat, nstg_of(sel));
            end
            n_vec++;
            if (cur_sum !== es) begin
                n_err++;
                $display("FAIL [cfg%0d] %s sum: got %h expected %h", sel, name, cur_sum, es);
            end
            n_vec++;
            if (cur_cout !== ec) begin
                n_err++;
                $display("FAIL [cfg%0d] %s cout: got %b expected %b", sel, name, cur_cout, ec);
            end
            n_vec++;
            if (cur_ovf !== eo) begin
                n_err++;
                $display("FAIL [cfg%0d] %s ovf: got %b expected %b", sel, name, cur_ovf, eo);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_drv = '0; b_drv = '0; cin_drv = 1'b0; sub_drv = 1'b0;
        tick();
        tick();
        n_vec++;
        if (cur_valid !== 1'b0 || cur_sum !== 64'd0 || cur_cout !== 1'b0 || cur_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL [cfg%0d] reset state: got v=%b sum=%h c=%b o=%b expected all 0",
                     sel, cur_valid, cur_sum, cur_cout, cur_ovf);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (cur_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL [cfg%0d] reset in_ready: got %b expected 1", sel, cur_in_ready);
        end
        tick();
    endtask

    task automatic test_single();
        run_one("single_add", 64'hFF, 64'h1, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0);
    endtask

    task automatic test_ripple();
        logic [63:0] m;
        m = mask_of(width_of(sel));
        run_one("ripple_all_ones_cin", m, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_one("ripple_max_pos_plus1", m >> 1, 64'd1, 1'b0, 1'b0,
                64'd1 << (width_of(sel) - 1), 1'b0, 1'b1);
        run_one("ripple_ones_plus_ones", m, m, 1'b1, 1'b0, m, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        logic [63:0] m;
        logic [63:0] r;
        m = mask_of(width_of(sel));
        r = {$urandom, $urandom} & m;
        run_one("sub_5_minus_7", 64'd5, 64'd7, 1'b1, 1'b1, m - 64'd1, 1'b0, 1'b0);
        run_one("sub_min_minus_1", 64'd1 << (width_of(sel) - 1), 64'd1, 1'b0, 1'b1,
                m >> 1, 1'b1, 1'b1);
        run_one("sub_equal", r, r, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
    endtask

    // 20 back-to-back random ops with random backpressure.
    task automatic test_back_to_back();
        res_t        exp_q[$];
        res_t        e;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        int          w;
        bit          stalled = 0;
        logic [63:0] hold_sum;
        logic        hold_c, hold_o;
        w = width_of(sel);
        while (got < 20 && cyc < 600) begin
            if (stalled) begin
                n_vec++;
                if (cur_valid !== 1'b1 || cur_sum !== hold_sum || cur_cout !== hold_c || cur_ovf !== hold_o) begin
                    n_err++;
                    $display("FAIL [cfg%0d] stall_hold: got v=%b sum=%h expected v=1 sum=%h",
                             sel, cur_valid, cur_sum, hold_sum);
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (sent < 20);
            a_drv     = {$urandom, $urandom};
            b_drv     = {$urandom, $urandom};
            cin_drv   = 1'($urandom_range(0, 1));
            sub_drv   = 1'($urandom_range(0, 1));
            #1;
            n_vec++;
            if (cur_in_ready !== (!cur_valid || out_ready)) begin
                n_err++;
                $display("FAIL [cfg%0d] in_ready_rule: got %b expected %b",
                         sel, cur_in_ready, (!cur_valid || out_ready));
            end
            if (in_valid && cur_in_ready) begin
                exp_q.push_back(model(a_drv, b_drv, cin_drv, sub_drv, w));
                sent++;
            end
            if (cur_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL [cfg%0d] stream extra result: got sum=%h expected none", sel, cur_sum);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_sum !== e.sum || cur_cout !== e.cout || cur_ovf !== e.ovf) begin
                        n_err++;
                        $display("FAIL [cfg%0d] stream result %0d: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                                 sel, got, cur_sum, cur_cout, cur_ovf, e.sum, e.cout, e.ovf);
                    end
                    got++;
                end
            end
            stalled  = cur_valid && !out_ready;
            hold_sum = cur_sum;
            hold_c   = cur_cout;
            hold_o   = cur_ovf;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (got < 20) begin
            n_err++;
            $display("FAIL [cfg%0d] stream timeout: got %0d results expected 20", sel, got);
        end
        for (int i = 0; i < nstg_of(sel) + 2; i++) begin
            n_vec++;
            if (cur_valid !== 1'b0) begin
                n_err++;
                $display("FAIL [cfg%0d] stream drain: got out_valid=%b expected 0", sel, cur_valid);
            end
            tick();
        end
    endtask

    // Three ops in flight, reset before any reaches the output.
    task automatic test_reset_mid_flight();
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a_drv    = {$urandom, $urandom};
            b_drv    = {$urandom, $urandom};
            cin_drv  = 1'b1;
            sub_drv  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (cur_valid !== 1'b0 || cur_sum !== 64'd0) begin
            n_err++;
            $display("FAIL [cfg%0d] mid_flight_reset: got v=%b sum=%h expected v=0 sum=0",
                     sel, cur_valid, cur_sum);
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (cur_valid !== 1'b0) begin
                n_err++;
                $display("FAIL [cfg%0d] stale result after reset: got out_valid=%b expected 0", sel, cur_valid);
            end
            tick();
        end
        e = model(64'h1234_5678, 64'h0FED_CBA9, 1'b0, 1'b1, width_of(sel));
        run_one("after_reset", 64'h1234_5678, 64'h0FED_CBA9, 1'b0, 1'b1, e.sum, e.cout, e.ovf);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_drv = '0; b_drv = '0; cin_drv = 1'b0; sub_drv = 1'b0; sel = 0;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            test_reset();
            test_single();
            test_ripple();
            test_sub();
            test_back_to_back();
        end
        sel = 0;
        test_reset();
        test_reset_mid_flight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the team's fixed 32-bit ripple-carry adder.
- Splits the WIDTH-bit add into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. Accepts one operation per clock at full throughput.
- Adds a valid/ready handshake with backpressure, a subtract mode and a signed-overflow flag. Sits between operand register files and result consumers in datapath blocks.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; NSTG = WIDTH/CHUNK stages (default 4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB slice. For sub this is NOT borrow: cout=1 means a>=b unsigned.
- ovf  out  1  two's-complement overflow.

Behaviour:
- Arithmetic:
  - beff = sub ? ~b : b; c0 = sub ? 1 : cin.
  - {cout,sum} = a + beff + c0 at WIDTH+1 bits.
  - ovf = (a[MSB] == beff[MSB]) && (sum[MSB] != a[MSB]).
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
  - When adv=1, every stage register loads from the previous stage: valid bit, partial sum, carry, pending upper operand bits, ovf-qualifying bits.
  - When adv=0, every register holds, and in_valid is ignored.
- Stage k (0..NSTG-1) adds slice k of a/beff plus the carry from stage k-1 (c0 for k=0).
  - Lower result slices travel forward unchanged.
  - Unused upper operand slices are delayed alongside.
- Latency: a result accepted at edge T appears with out_valid=1 after edge T+NSTG-1, i.e. NSTG register stages; the output register is the last stage.
- Throughput: one op per cycle while out_ready=1. Back-to-back ops stay in order; no reordering and no bubble insertion.
- Bubbles: a stage with valid=0 still shifts when adv=1. Bubbles are not compressed (global-stall pipeline).
- Stall: when out_ready=0 with out_valid=1:
  - sum/cout/ovf are held stable until the transfer.
  - in_ready=0 in the same cycle.
- Reset (sync, rst=1 at an edge):
  - All stage valid bits clear to 0; out_valid=0.
  - sum, cout, ovf and all data registers clear to 0.
  - in_ready=1 in the cycle after reset, since out_valid=0.
  - In-flight ops are discarded with no output.
  - rst takes priority over adv.
- Boundaries:
  - a=b=all-ones with cin=1 -> sum=all-ones, cout=1.
  - sub with a==b -> sum=0, cout=1, ovf=0.
  - NSTG=1 (CHUNK=WIDTH) must work as a single registered adder with latency 1.
  - outputs are defined (held/0) even when out_valid=0; consumers must ignore them.

Decomposition:
- Shared package/header holds:
  - function or localparam NSTG = WIDTH/CHUNK;
  - an elaboration-time check that WIDTH % CHUNK == 0 (fatal on violation).
- One sub-module, adder_slice: CHUNK-bit combinational add with carry in/out, instantiated NSTG times in a generate loop.
- Pipeline registers live in pipe_adder.

Test Plan (WIDTH=32, CHUNK=8, NSTG=4):
1. Single add: rst 2 cycles, then a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0, out_ready=1 -> out_valid rises 4 cycles later; sum=0x0000_0100, cout=0, ovf=0; in_ready=1 throughout.
2. Full carry ripple: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, ovf=1.
3. Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0. Then a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
4. Streaming with backpressure: 20 random ops back-to-back; out_ready toggles randomly. Required:
   - results match the a+beff+c0 model in order, with no loss or duplication;
   - sum is stable while out_valid && !out_ready;
   - in_ready == (!out_valid || out_ready) on every cycle.
5. Reset mid-flight: 3 ops accepted, rst asserted for 1 cycle before any output -> out_valid=0 and sum=0 after that edge; no stale result ever appears. A new op after reset returns correctly 4 cycles later.
6. Parameter sweep: rerun scenarios 1-4 with (WIDTH,CHUNK) = (32,32), (16,4) and (64,16). Latency must equal WIDTH/CHUNK; results match the model.
